// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared 8:1 32-bit selector.
// Picks one requester per transfer, captures its word and offers it on valid/ready.

module mux_8x1_32bit (
    input  logic [2:0]   sel,
    input  logic [255:0] in_data,
    output logic [31:0]  out_data
);
    logic [31:0] w_slot [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            assign w_slot[gi] = in_data[32*gi +: 32];
        end
    endgenerate

    assign out_data = w_slot[sel];
endmodule

module mux8_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int RESET_PTR = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   req,
    input  logic [7:0]   lock,
    input  logic [255:0] in_data,
    output logic [7:0]   ack,
    output logic [2:0]   sel,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam logic [2:0] BURST_LIM = 3'(MAX_BURST - 1);
    localparam logic [2:0] PTR_INIT  = 3'(RESET_PTR);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t      r_state;
    logic [2:0]  r_sel;
    logic [2:0]  r_burst_cnt;
    logic [31:0] r_out_data;
    logic        r_out_valid;

    logic        w_load;
    logic        w_keep;
    logic        w_scan_found;
    logic [2:0]  w_scan_idx;
    logic [2:0]  w_winner;
    logic [2:0]  w_burst_next;
    logic [31:0] w_mux_data;

    assign w_load = (|req) & (~r_out_valid | out_ready);

    // Scan starts just after the previous winner; the previous winner itself is checked last.
    always_comb begin
        w_scan_found = 1'b0;
        w_scan_idx   = r_sel;
        for (int k = 1; k <= 8; k++) begin
            if (!w_scan_found && req[r_sel + 3'(k)]) begin
                w_scan_found = 1'b1;
                w_scan_idx   = r_sel + 3'(k);
            end
        end
    end

    assign w_keep   = req[r_sel] & lock[r_sel] & (r_burst_cnt < BURST_LIM);
    assign w_winner = w_keep ? r_sel : w_scan_idx;

    always_comb begin
        w_burst_next = r_burst_cnt;
        if (w_keep) begin
            w_burst_next = r_burst_cnt + 3'd1;
        end else if (w_winner != r_sel) begin
            w_burst_next = 3'd0;
        end else if (r_burst_cnt < BURST_LIM) begin
            w_burst_next = r_burst_cnt + 3'd1;
        end else begin
            w_burst_next = BURST_LIM;
        end
    end

    mux_8x1_32bit u_mux (
        .sel      (w_winner),
        .in_data  (in_data),
        .out_data (w_mux_data)
    );

    // Ack is gated by rst_n so nothing is acknowledged for a transfer aborted by reset.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ack
            assign ack[gi] = rst_n & w_load & (w_winner == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_sel       <= PTR_INIT;
            r_burst_cnt <= 3'd0;
            r_out_data  <= 32'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_load) begin
                        r_state     <= ST_FULL;
                        r_sel       <= w_winner;
                        r_burst_cnt <= w_burst_next;
                        r_out_data  <= w_mux_data;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_load) begin
                        r_sel       <= w_winner;
                        r_burst_cnt <= w_burst_next;
                        r_out_data  <= w_mux_data;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = r_sel;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: rotation, wrap, lock bursts, backpressure, async reset.
`timescale 1ns/1ps
module tb_mux8_rr_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   req;
    logic [7:0]   lock;
    logic [255:0] in_data;
    logic [7:0]   ack;
    logic [2:0]   sel;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.MAX_BURST(4), .RESET_PTR(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .in_data   (in_data),
        .ack       (ack),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [31:0] slotv(input int i);
        return 32'hA5A5_0000 | 32'(i * 32'h11);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expects a grant to requester w in the current cycle.
    task automatic grant(input int w, input string tag);
        logic [7:0] e;
        e = 8'd1 << w;
        @(negedge clk);
        chk({tag, "_ack"}, {24'd0, ack}, {24'd0, e});
        @(posedge clk); #1;
        $display("%s: grant expected=%0d sel=%0d data=%h valid=%b", tag, w, sel, out_data, out_valid);
        chk({tag, "_sel"}, {29'd0, sel}, 32'(w));
        chk({tag, "_data"}, out_data, in_data[32*w +: 32]);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    // Expects no grant; state after the edge must equal the given values.
    task automatic idle(input int s, input logic [31:0] d, input logic v, input string tag);
        @(negedge clk);
        chk({tag, "_ack"}, {24'd0, ack}, 32'd0);
        @(posedge clk); #1;
        $display("%s: idle sel=%0d data=%h valid=%b", tag, sel, out_data, out_valid);
        chk({tag, "_sel"}, {29'd0, sel}, 32'(s));
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req       = 8'hFF;
        lock      = 8'h00;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_data[32*i +: 32] = slotv(i);

        // Reset state, with requests already present
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sel", {29'd0, sel}, 32'd7);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ack", {24'd0, ack}, 32'd0);
        $display("reset: sel=%0d data=%h valid=%b ack=%b", sel, out_data, out_valid, ack);
        rst_n = 1'b1;

        // 1. Full rotation with wrap back to 0
        for (int i = 0; i < 8; i++) grant(i, "rot");
        grant(0, "rot_wrap");

        // 2. Wrap from pointer 5
        req = 8'b0010_0000;
        grant(5, "wrap_pre");
        req = 8'b0010_0001;
        grant(0, "wrap_a");
        grant(5, "wrap_b");
        grant(0, "wrap_c");

        // 3. Locked burst limited to MAX_BURST
        req  = 8'b0000_1100;
        lock = 8'b0000_0100;
        grant(2, "burst1");
        grant(2, "burst2");
        grant(2, "burst3");
        grant(2, "burst4");
        grant(3, "burst_brk");
        grant(2, "burst_ret");

        // 4. Backpressure holds the word, then drain to EMPTY
        lock = 8'h00;
        req  = 8'b0001_0000;
        in_data[32*4 +: 32] = 32'hDEAD_BEEF;
        grant(4, "bp_load");
        out_ready = 1'b0;
        in_data[32*4 +: 32] = 32'h1234_5678;
        idle(4, 32'hDEAD_BEEF, 1'b1, "bp_hold1");
        idle(4, 32'hDEAD_BEEF, 1'b1, "bp_hold2");
        idle(4, 32'hDEAD_BEEF, 1'b1, "bp_hold3");
        out_ready = 1'b1;
        req = 8'h00;
        idle(4, 32'hDEAD_BEEF, 1'b0, "bp_drain");
        idle(4, 32'hDEAD_BEEF, 1'b0, "empty_idle");

        // 6. Single streamer, lock on an idle requester is ignored
        req  = 8'b0100_0000;
        lock = 8'b0001_0000;
        for (int i = 0; i < 6; i++) grant(6, "stream6");

        // 5. Async reset while FULL with backpressure
        lock = 8'h00;
        req  = 8'h01;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst5_ack_pre", {24'd0, ack}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst5_valid", {31'd0, out_valid}, 32'd0);
        chk("rst5_sel", {29'd0, sel}, 32'd7);
        chk("rst5_ack", {24'd0, ack}, 32'd0);
        chk("rst5_data", out_data, 32'd0);
        $display("rst5: sel=%0d data=%h valid=%b ack=%b", sel, out_data, out_valid, ack);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst5_post_ack", {24'd0, ack}, 32'd1);
        @(posedge clk); #1;
        $display("rst5_post: sel=%0d data=%h valid=%b", sel, out_data, out_valid);
        chk("rst5_post_sel", {29'd0, sel}, 32'd0);
        chk("rst5_post_data", out_data, slotv(0));
        chk("rst5_post_valid", {31'd0, out_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
